// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a length-prefixed byte stream into big-endian
// 32-bit word writes from address 0, and holds the CPU stalled until the image is in.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_run,
  output logic              err,
  output logic [15:0]       words_written
);

  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, FLUSH, DONE} state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t      state;
  logic [7:0]  n_hi;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;

  logic        accept;
  logic [15:0] hdr_n;
  logic [31:0] word;

  assign accept = in_valid && in_ready;
  assign hdr_n  = {n_hi, in_data};
  // The final byte bypasses the assembly register so the write lands on its accept edge.
  assign word   = {asm_q, in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HDR_HI;
      in_ready      <= 1'b1;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      cpu_run       <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
      n_hi          <= '0;
      n_words       <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      asm_q         <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        HDR_HI: if (accept) begin
          n_hi  <= in_data;
          state <= HDR_LO;
        end
        HDR_LO: if (accept) begin
          n_words  <= hdr_n;
          byte_idx <= '0;
          word_idx <= '0;
          if (hdr_n > DEPTH16) err <= 1'b1;
          if (hdr_n == 16'd0) begin
            state    <= DONE;
            cpu_run  <= 1'b1;
            in_ready <= 1'b0;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (accept) begin
          asm_q    <= {asm_q[15:0], in_data};
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            // Words past DEPTH are consumed but never written, so the address never wraps.
            if (word_idx < DEPTH16) begin
              wr_en         <= 1'b1;
              wr_addr       <= {word_idx[ADDR_W-3:0], 2'b00};
              wr_data       <= word;
              words_written <= words_written + 16'd1;
            end
            word_idx <= word_idx + 16'd1;
            if (word_idx == n_words - 16'd1) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          state   <= DONE;
          cpu_run <= 1'b1;
        end
        DONE: if (reload) begin
          state         <= HDR_HI;
          in_ready      <= 1'b1;
          cpu_run       <= 1'b0;
          err           <= 1'b0;
          words_written <= '0;
        end
        default: state <= HDR_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a DEPTH=64 and a DEPTH=2 instance share one byte stream;
// expected writes are queued per instance and matched as strobes appear.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        reload = 1'b0;

  logic        in_ready_a, wr_en_a, cpu_run_a, err_a;
  logic [7:0]  wr_addr_a;
  logic [31:0] wr_data_a;
  logic [15:0] words_written_a;

  logic        in_ready_b, wr_en_b, cpu_run_b, err_b;
  logic [7:0]  wr_addr_b;
  logic [31:0] wr_data_b;
  logic [15:0] words_written_b;

  int checks = 0;
  int errors = 0;
  logic [39:0] q_a[$];
  logic [39:0] q_b[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .reload(reload), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .cpu_run(cpu_run_a), .err(err_a), .words_written(words_written_a)
  );

  imem_loader #(.ADDR_W(8), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .reload(reload), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .cpu_run(cpu_run_b), .err(err_b), .words_written(words_written_b)
  );

  // Advance one clock and match any write strobe against the scoreboards.
  task automatic tick();
    logic [39:0] e;
    @(posedge clk); #1;
    if (wr_en_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++; $display("FAIL wr_a_spurious got addr=%h data=%h, none expected", wr_addr_a, wr_data_a);
      end else begin
        e = q_a.pop_front();
        if ({wr_addr_a, wr_data_a} !== e) begin
          errors++; $display("FAIL wr_a got %h_%h expected %h_%h", wr_addr_a, wr_data_a, e[39:32], e[31:0]);
        end
      end
    end
    if (wr_en_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++; $display("FAIL wr_b_spurious got addr=%h data=%h, none expected", wr_addr_b, wr_data_b);
      end else begin
        e = q_b.pop_front();
        if ({wr_addr_b, wr_data_b} !== e) begin
          errors++; $display("FAIL wr_b got %h_%h expected %h_%h", wr_addr_b, wr_data_b, e[39:32], e[31:0]);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready_a && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout byte=%h in_ready stayed 0, required 1", b);
    end
    tick();
    in_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
  endtask

  task automatic push_both(input logic [7:0] addr, input logic [31:0] data);
    q_a.push_back({addr, data});
    q_b.push_back({addr, data});
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({in_ready_a, wr_en_a, wr_addr_a, wr_data_a, cpu_run_a, err_a, words_written_a} !==
        {1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL %s_a rdy=%b wr=%b addr=%h data=%h run=%b err=%b ww=%0d required 1 0 00 0 0 0 0",
               tag, in_ready_a, wr_en_a, wr_addr_a, wr_data_a, cpu_run_a, err_a, words_written_a);
    end
    checks++;
    if ({in_ready_b, wr_en_b, cpu_run_b, err_b, words_written_b} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL %s_b rdy=%b wr=%b run=%b err=%b ww=%0d required 1 0 0 0 0",
               tag, in_ready_b, wr_en_b, cpu_run_b, err_b, words_written_b);
    end
  endtask

  // Two-word image; checks the flush/run timing after the final byte.
  task automatic load_two(input bit gap, input string tag);
    send_byte(8'h00, gap);
    send_byte(8'h02, gap);
    push_both(8'h00, 32'h12345678);
    send_word(32'h12345678, gap);
    push_both(8'h04, 32'hAABBCCDD);
    send_word(32'hAABBCCDD, 1'b0);
    checks++;
    if ({wr_en_a, in_ready_a, cpu_run_a} !== 3'b100) begin
      errors++; $display("FAIL %s_flush wr/rdy/run=%b required 100", tag, {wr_en_a, in_ready_a, cpu_run_a});
    end
    tick();
    checks++;
    if ({wr_en_a, in_ready_a, cpu_run_a, cpu_run_b} !== 4'b0011) begin
      errors++; $display("FAIL %s_done wr/rdy/run_a/run_b=%b required 0011", tag, {wr_en_a, in_ready_a, cpu_run_a, cpu_run_b});
    end
    checks++;
    if (words_written_a !== 16'd2 || words_written_b !== 16'd2 || err_a !== 1'b0 || err_b !== 1'b0) begin
      errors++; $display("FAIL %s_count ww_a=%0d ww_b=%0d err=%b%b required 2 2 00", tag, words_written_a, words_written_b, err_a, err_b);
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    check_reset_vals("reset_init");
    rst_n = 1'b1;
    tick();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_midword");
    tick();
    rst_n = 1'b1;
    tick();
    load_two(1'b0, "reset_fresh");
  endtask

  task automatic test_basic();
    pulse_reload();
    load_two(1'b0, "basic");
  endtask

  task automatic test_empty();
    pulse_reload();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++;
    if ({cpu_run_a, cpu_run_b, in_ready_a, words_written_a} !== {3'b110, 16'd0}) begin
      errors++; $display("FAIL empty run_a/run_b/rdy=%b ww=%0d required 110 0", {cpu_run_a, cpu_run_b, in_ready_a}, words_written_a);
    end
    tick(); tick();
  endtask

  task automatic test_gapped();
    pulse_reload();
    load_two(1'b1, "gapped");
  endtask

  task automatic test_overflow();
    pulse_reload();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    checks++;
    if (err_b !== 1'b1 || err_a !== 1'b0) begin
      errors++; $display("FAIL ovf_err err_b=%b err_a=%b required 1 0", err_b, err_a);
    end
    push_both(8'h00, 32'h01020304);
    send_word(32'h01020304, 1'b0);
    push_both(8'h04, 32'h05060708);
    send_word(32'h05060708, 1'b0);
    q_a.push_back({8'h08, 32'h090A0B0C});
    send_word(32'h090A0B0C, 1'b0);
    tick();
    checks++;
    if ({cpu_run_a, cpu_run_b, err_b} !== 3'b111) begin
      errors++; $display("FAIL ovf_done run_a/run_b/err_b=%b required 111", {cpu_run_a, cpu_run_b, err_b});
    end
    checks++;
    if (words_written_b !== 16'd2 || words_written_a !== 16'd3) begin
      errors++; $display("FAIL ovf_count ww_b=%0d ww_a=%0d required 2 3", words_written_b, words_written_a);
    end
  endtask

  task automatic test_reload();
    pulse_reload();
    checks++;
    if ({cpu_run_b, err_b, in_ready_b, words_written_b} !== {3'b001, 16'd0}) begin
      errors++; $display("FAIL reload_clear run/err/rdy=%b ww=%0d required 001 0", {cpu_run_b, err_b, in_ready_b}, words_written_b);
    end
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    push_both(8'h00, 32'hDEADBEEF);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    pulse_reload();
    checks++;
    if (cpu_run_a !== 1'b0 || in_ready_a !== 1'b1) begin
      errors++; $display("FAIL reload_in_data run=%b rdy=%b required 0 1", cpu_run_a, in_ready_a);
    end
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    tick();
    checks++;
    if ({cpu_run_a, cpu_run_b, err_b} !== 3'b110 || words_written_a !== 16'd1) begin
      errors++; $display("FAIL reload_done run_a/run_b/err_b=%b ww=%0d required 110 1", {cpu_run_a, cpu_run_b, err_b}, words_written_a);
    end
  endtask

  task automatic test_drain();
    tick(); tick();
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++; $display("FAIL drain pending writes a=%0d b=%0d required 0 0", q_a.size(), q_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_gapped();
    test_overflow();
    test_reload();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface; the fetch unit is the reader.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word-aligned byte addresses starting at 0.
- Holds the CPU stalled (cpu_run=0) until the whole program image is written.

Parameters:
ADDR_W, 8, byte-address width of instruction memory write port
DEPTH, 64, number of 32-bit words the instruction memory holds (DEPTH*4 <= 2^ADDR_W)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  in_data holds a valid byte
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
reload  input  1  one-cycle pulse; restarts loading, honoured only in DONE
wr_en  output  1  one-cycle instruction-memory write strobe
wr_addr  output  ADDR_W  byte address of write, always multiple of 4
wr_data  output  32  instruction word
cpu_run  output  1  program loaded; CPU may fetch
err  output  1  sticky: header word count exceeded DEPTH
words_written  output  16  count of words actually written this load

Behaviour:
- Handshake: byte accepted on a rising edge where in_valid && in_ready. in_ready is registered state only, never a function of in_valid.
- Stream format:
  - 2-byte header N (word count, high byte first).
  - Then 4*N bytes, each word most-significant byte first.
- States: HDR_HI, HDR_LO, DATA, FLUSH, DONE.
- Reset (async, rst_n=0): state=HDR_HI; in_ready=1; wr_en=0; wr_addr=0; wr_data=0; cpu_run=0; err=0; words_written=0.
  - Any partial header or word is discarded.
  - Memory contents are not touched.
- HDR_HI: on accept, latch N[15:8] -> HDR_LO.
- HDR_LO: on accept, latch N[7:0].
  - If N > DEPTH, set err=1.
  - If N==0 -> DONE, cpu_run=1 at that same edge.
  - Otherwise -> DATA with byte index 0, word index 0.
- DATA: in_ready=1; shift each accepted byte into a 32-bit assembly register.
  - On acceptance of byte 3 of a word, at the same edge:
    - If word index < DEPTH: wr_en<=1, wr_addr<=word_index*4, wr_data<=assembled word, words_written++.
    - Otherwise: wr_en stays 0 and the word is discarded.
    - Word index increments.
  - wr_en is high for exactly the following cycle only.
  - If that byte completes word N-1 -> FLUSH.
- FLUSH: in_ready=0; lasts one cycle (covers the final wr_en pulse); next edge -> DONE with cpu_run<=1.
  - cpu_run therefore rises one cycle after the final write strobe.
- DONE: in_ready=0, cpu_run=1, wr_en=0. Incoming bytes are not accepted.
  - reload=1 -> HDR_HI at the next edge, with cpu_run<=0, err<=0, words_written<=0.
- reload outside DONE is ignored.
- Gaps with in_valid=0 are allowed anywhere; partial state is held.
- Word index and N are 16-bit; the index never wraps because loading stops at N.
- Overflowing words (index >= DEPTH) are consumed and dropped; no address wrap.
- words_written saturates at DEPTH by construction.

Test Plan:
- Reset mid-word: header 0x0002, bytes 0x12,0x34, then rst_n=0 -> all outputs at reset values, in_ready=1. A fresh load afterwards writes from address 0.
- Basic load: stream 00 02 | 12 34 56 78 | AA BB CC DD, in_valid held high -> two pulses: (addr 0x00, 0x12345678) then (addr 0x04, 0xAABBCCDD). in_ready=0 the cycle after the last byte. cpu_run=1 one cycle after the second pulse. words_written=2.
- Empty program: stream 00 00 -> no wr_en pulses; cpu_run=1 at the edge accepting the second byte.
- Gapped valid: same stream as basic load with in_valid toggling every other cycle -> identical writes and data, only delayed; no spurious wr_en.
- Overflow, DEPTH=2: header 00 03 plus 12 bytes -> err=1 after the header; writes only at 0x00 and 0x04; third word dropped; cpu_run=1 after the last byte; words_written=2.
- Reload: after DONE, pulse reload, then load 00 01 | DE AD BE EF -> cpu_run drops to 0, err cleared, one write (0x00, 0xDEADBEEF), cpu_run returns to 1. A reload pulse during DATA has no effect.
